// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default sizing for the unified fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int DEF_AW       = 32;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Bits needed to hold a counter that reaches n (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and memory port of the arbiter grouped as one bundle.
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_pick.sv
// Fetch/data priority select with an anti-starvation counter for fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    localparam int SW = cnt_w(MAX_WAIT);
    localparam logic [SW-1:0] SAT = SW'(MAX_WAIT);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        starve_d = starve_q;
        // Data normally wins; fetch is forced through once it has lost MAX_WAIT times.
        if (arb_en) begin
            if (if_req && (!d_req || starve_q == SAT)) grant_i = 1'b1;
            else if (d_req)                           grant_d = 1'b1;
        end
        if (grant_i)                                    starve_d = '0;
        else if (grant_d && if_req && starve_q != SAT)  starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch and data access, one access at a time.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus
);
    localparam int WW = cnt_w(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rsp_err_q, rsp_err_d;
    owner_t        rsp_own_q, rsp_own_d;
    logic          grant_i, grant_d;

    // Grants are held off while reset is asserted so every output reads 0.
    mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .clk     (clk),
        .reset   (reset),
        .arb_en  ((state_q == IDLE) && reset),
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = '0;
        rsp_err_d   = 1'b0;
        rsp_own_d   = OWN_NONE;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    wait_d      = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Response is registered and presented to the owner on the following IDLE cycle.
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    rsp_own_d = (state_q == BUSY_I) ? OWN_I : OWN_D;
                    rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    rsp_own_d = (state_q == BUSY_I) ? OWN_I : OWN_D;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_own_q   <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_own_q   <= rsp_own_d;
        end
    end

    assign bus.if_gnt    = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = (rsp_own_q == OWN_I);
    assign bus.d_rvalid  = (rsp_own_q == OWN_D);
    assign bus.if_rdata  = (rsp_own_q == OWN_I) ? rdata_q : '0;
    assign bus.d_rdata   = (rsp_own_q == OWN_D) ? rdata_q : '0;
    assign bus.if_err    = (rsp_own_q == OWN_I) && rsp_err_q;
    assign bus.d_err     = (rsp_own_q == OWN_D) && rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level transaction model.
module tb_unified_mem_arbiter;
    localparam int AW = 32, DW = 32, MAX_WAIT = 4, TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int vectors = 0, miscompares = 0;

    task automatic quiet_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.if_req = 1'(c != 1); bus.d_req = 1'(c != 0); bus.mem_ready = 1'b1;
            bus.if_addr = $urandom; bus.d_addr = $urandom; bus.mem_rdata = $urandom;
            #1;
            vectors++;
            if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_req, bus.mem_we} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b want 00000000", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_req, bus.mem_we});
            end
            vectors++;
            if ({bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_data: got %h want 0", {bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata});
            end
        end
        @(negedge clk);
        quiet_inputs();
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        vectors++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_req} !== 3'b100) begin
            miscompares++; $display("FAIL fetch_gnt: got %b want 100", {bus.if_gnt, bus.d_gnt, bus.mem_req});
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({bus.if_gnt, bus.mem_req, bus.mem_we, bus.mem_addr} !== {3'b010, 32'h100}) begin
            miscompares++; $display("FAIL fetch_mem: got %h want %h", {bus.if_gnt, bus.mem_req, bus.mem_we, bus.mem_addr}, {3'b010, 32'h100});
        end
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0050_0093;
        #1;
        vectors++;
        if ({bus.mem_req, bus.if_rvalid} !== 2'b10) begin
            miscompares++; $display("FAIL fetch_wait: got %b want 10", {bus.mem_req, bus.if_rvalid});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h1111_1111;
        #1;
        vectors++;
        if ({bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.mem_req, bus.if_rdata} !== {4'b1000, 32'h0050_0093}) begin
            miscompares++; $display("FAIL fetch_rsp: got %h want %h", {bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.mem_req, bus.if_rdata}, {4'b1000, 32'h0050_0093});
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.if_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL fetch_pulse: got %b want 0", bus.if_rvalid);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            miscompares++; $display("FAIL store_gnt: got %b want 01", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk);
        quiet_inputs();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h2000, 32'hDEAD_BEEF}) begin
            miscompares++; $display("FAIL store_mem: got %h want %h", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 32'h2000, 32'hDEAD_BEEF});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        vectors++;
        if ({bus.d_rvalid, bus.d_err, bus.if_rvalid, bus.d_rdata} !== {3'b100, 32'h0}) begin
            miscompares++; $display("FAIL store_rsp: got %h want %h", {bus.d_rvalid, bus.d_err, bus.if_rvalid, bus.d_rdata}, {3'b100, 32'h0});
        end
    endtask

    task automatic test_starve();
        int n = 0;
        logic want_i;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 32'h400 + 32'(c);
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8000 + 32'(c);
            bus.mem_ready = bus.mem_req; bus.mem_rdata = $urandom;
            #1;
            if (bus.if_gnt || bus.d_gnt) begin
                want_i = (n % 5 == 4);
                vectors++;
                if ({bus.if_gnt, bus.d_gnt} !== {want_i, !want_i}) begin
                    miscompares++; $display("FAIL starve_order: grant %0d got %b want %b", n, {bus.if_gnt, bus.d_gnt}, {want_i, !want_i});
                end
                n++;
            end
        end
        vectors++;
        if (n != 20) begin
            miscompares++; $display("FAIL starve_count: got %0d want 20", n);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            quiet_inputs();
            bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        quiet_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
        #1;
        vectors++;
        if (bus.d_gnt !== 1'b1) begin
            miscompares++; $display("FAIL tmo_gnt: got %b want 1", bus.d_gnt);
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            quiet_inputs();
            bus.mem_rdata = 32'hA5A5_A5A5;
            #1;
            vectors++;
            if ({bus.mem_req, bus.d_rvalid} !== 2'b10) begin
                miscompares++; $display("FAIL tmo_busy: cycle %0d got %b want 10", k, {bus.mem_req, bus.d_rvalid});
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.mem_req, bus.d_rvalid, bus.d_err, bus.d_rdata} !== {3'b011, 32'h0}) begin
            miscompares++; $display("FAIL tmo_rsp: got %h want %h", {bus.mem_req, bus.d_rvalid, bus.d_err, bus.d_rdata}, {3'b011, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        quiet_inputs();
        bus.if_req = 1'b1; bus.if_addr = 32'h440;
        #1;
        vectors++;
        if (bus.if_gnt !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_gnt: got %b want 1", bus.if_gnt);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.if_req = 1'b0;
            if (k == 3) begin reset = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; end
        end
        @(negedge clk);
        reset = 1'b1; bus.mem_ready = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        #1;
        vectors++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_req, bus.mem_we} !== 6'b0) begin
            miscompares++; $display("FAIL rstmid_ctrl: got %b want 000000", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.mem_req, bus.mem_we});
        end
        vectors++;
        if ({bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
            miscompares++; $display("FAIL rstmid_data: got %h want 0", {bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata});
        end
        vectors++;
        if (bus.if_gnt !== 1'b1) begin
            miscompares++; $display("FAIL first_gnt: got %b want 1", bus.if_gnt);
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
        #1;
        vectors++;
        if ({bus.mem_req, bus.if_rvalid, bus.mem_addr} !== {2'b10, 32'h500}) begin
            miscompares++; $display("FAIL rstmid_mem: got %h want %h", {bus.mem_req, bus.if_rvalid, bus.mem_addr}, {2'b10, 32'h500});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        vectors++;
        if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b10, 32'h13}) begin
            miscompares++; $display("FAIL rstmid_rsp: got %h want %h", {bus.if_rvalid, bus.if_err, bus.if_rdata}, {2'b10, 32'h13});
        end
    endtask

    // Model: owner of the memory (0 none, 1 fetch, 2 data), cycles waited, pending response.
    task automatic test_random();
        int m_own = 0, m_elapsed = 0, m_starve = 0, m_lat = 0, m_rsp = 0;
        logic m_we = 1'b0, m_err = 1'b0, i_pend = 1'b0, d_pend = 1'b0, exp_ig, exp_dg;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wdata = '0, m_data = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1'b1; bus.if_addr = $urandom; end
            if (!d_pend && $urandom_range(0, 1) == 0) begin
                d_pend = 1'b1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
            bus.if_req = i_pend; bus.d_req = d_pend;
            bus.mem_rdata = $urandom;
            bus.mem_ready = (m_own != 0) ? (m_elapsed == m_lat) : ($urandom_range(0, 3) == 0);
            #1;
            exp_ig = (m_own == 0) && i_pend && (!d_pend || m_starve == MAX_WAIT);
            exp_dg = (m_own == 0) && d_pend && !exp_ig;
            vectors++;
            if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_req} !== {exp_ig, exp_dg, m_rsp == 1, m_rsp == 2, m_own != 0}) begin
                miscompares++;
                $display("FAIL rnd_ctrl: cycle %0d got %b want %b", c, {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_req}, {exp_ig, exp_dg, m_rsp == 1, m_rsp == 2, m_own != 0});
            end
            if (m_rsp != 0) begin
                vectors++;
                if ((m_rsp == 1 ? {bus.if_err, bus.if_rdata} : {bus.d_err, bus.d_rdata}) !== {m_err, m_data}) begin
                    miscompares++;
                    $display("FAIL rnd_rsp: cycle %0d got %h %h / %h %h want %h", c, bus.if_err, bus.if_rdata, bus.d_err, bus.d_rdata, {m_err, m_data});
                end
            end
            if (m_own != 0) begin
                vectors++;
                if ({bus.mem_we, bus.mem_addr, (m_we ? bus.mem_wdata : m_wdata)} !== {m_we, m_addr, m_wdata}) begin
                    miscompares++;
                    $display("FAIL rnd_mem: cycle %0d got %h %h %h want %h %h %h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, m_we, m_addr, m_wdata);
                end
            end
            m_rsp = 0; m_err = 1'b0; m_data = '0;
            if (m_own != 0) begin
                if (bus.mem_ready) begin
                    m_rsp = m_own; m_data = m_we ? '0 : bus.mem_rdata; m_own = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TIMEOUT) begin m_rsp = m_own; m_err = 1'b1; m_own = 0; end
                end
            end else if (exp_ig || exp_dg) begin
                m_own = exp_ig ? 1 : 2;
                m_addr = exp_ig ? bus.if_addr : bus.d_addr;
                m_we = exp_ig ? 1'b0 : bus.d_we;
                m_wdata = exp_ig ? '0 : bus.d_wdata;
                m_elapsed = 0; m_lat = $urandom_range(0, TIMEOUT + 3);
                if (exp_ig) begin m_starve = 0; i_pend = 1'b0; end
                else begin
                    if (i_pend && m_starve < MAX_WAIT) m_starve++;
                    d_pend = 1'b0;
                end
            end
        end
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter
Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive data grants allowed while fetch waits.
REQ-004 Parameter TIMEOUT, default 16, maximum cycles waiting for mem_ready.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 if_req  input  1  fetch read request, held with if_addr until if_gnt.
REQ-008 if_addr  input  AW  fetch address (PC).
REQ-009 if_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-010 if_rvalid  output  1  one-cycle pulse, fetch complete.
REQ-011 if_rdata  output  DW  instruction, valid with if_rvalid.
REQ-012 if_err  output  1  fetch timed out, valid with if_rvalid.
REQ-013 d_req  input  1  data request, held with d_we/d_addr/d_wdata until d_gnt.
REQ-014 d_we  input  1  1 = store, 0 = load.
REQ-015 d_addr  input  AW  data address.
REQ-016 d_wdata  input  DW  store data.
REQ-017 d_gnt  output  1  one-cycle pulse, data request accepted.
REQ-018 d_rvalid  output  1  one-cycle pulse, load data or store completion.
REQ-019 d_rdata  output  DW  load data with d_rvalid; 0 for stores.
REQ-020 d_err  output  1  data access timed out, valid with d_rvalid.
REQ-021 mem_req  output  1  memory access active, held until mem_ready or timeout.
REQ-022 mem_we  output  1  memory write enable.
REQ-023 mem_addr  output  AW  registered memory address.
REQ-024 mem_wdata  output  DW  registered memory write data.
REQ-025 mem_rdata  input  DW  memory read data, valid when mem_ready=1.
REQ-026 mem_ready  input  1  memory completes access this cycle.
Function
REQ-027 FSM states IDLE, BUSY_I, BUSY_D; IDLE with no request stays IDLE.
REQ-028 IDLE with request: pulse gnt to winner, latch addr/we/wdata into mem_* registers, enter BUSY_I/BUSY_D; mem_req=1 from next cycle.
REQ-029 Arbitration on simultaneous if_req and d_req: data wins unless starve_cnt == MAX_WAIT, then fetch wins.
REQ-030 starve_cnt increments (saturating at MAX_WAIT) on each data grant while if_req=1; clears to 0 on every fetch grant.
REQ-031 No grant in BUSY states; request arriving in BUSY waits, one IDLE cycle always separates accesses.
REQ-032 BUSY with mem_ready=1: register mem_rdata, next cycle pulse owner rvalid with err=0, mem_req=0, state IDLE.
REQ-033 Store completion: d_rvalid pulse with d_rdata=0, d_err=0.
REQ-034 Wait counter clears on grant, increments each BUSY cycle with mem_ready=0; at TIMEOUT: mem_req=0, owner rvalid pulse with err=1, rdata=0, state IDLE.
REQ-035 mem_ready while IDLE is ignored; rvalid/gnt never asserted for non-owner.
REQ-036 Address wrap: mem_addr passed unmodified, no alignment checks.
Reset
REQ-037 reset=0 at clock edge, including mid-access: state IDLE, counters 0, all outputs 0, no rvalid pulse for aborted access.
REQ-038 First grant possible in first cycle after reset deasserts.
Structure
REQ-039 Package mem_arb_pkg holds state enum (IDLE, BUSY_I, BUSY_D), owner enum, and default parameter constants.
REQ-040 Sub-module mem_arb_pick holds priority selection and starve_cnt; FSM, timeout counter and datapath registers remain in top.
Verification
REQ-041 if_req addr 0x100, mem_ready after 2 cycles with rdata 0x00500093 -> if_gnt cycle 1, if_rvalid with 0x00500093, if_err=0.
REQ-042 d_req store addr 0x2000 wdata 0xDEADBEEF -> mem_we=1, mem_addr 0x2000, mem_wdata 0xDEADBEEF; d_rvalid with d_rdata=0.
REQ-043 if_req and d_req held continuously, MAX_WAIT=4 -> grant order D,D,D,D,I, repeating.
REQ-044 d_req load, mem_ready held 0 -> after 16 BUSY cycles mem_req drops, d_rvalid=1, d_err=1, d_rdata=0.
REQ-045 reset=0 on cycle 3 of BUSY_I, mem_ready=1 same cycle -> no if_rvalid, all outputs 0, state IDLE.
